// File: rtl/pad_gpio_sync_if.sv
// Pad-input conditioning bus: raw pad levels and filter controls in,
// conditioned pin values and edge pulses out.
interface pad_gpio_sync_if #(
    parameter int WIDTH  = 32,
    parameter int FILT_W = 4
);
    logic [WIDTH-1:0]  pad_din_i;
    logic [WIDTH-1:0]  pad_ie_i;
    logic [WIDTH-1:0]  filt_en_i;
    logic [FILT_W-1:0] filt_thresh_i;
    logic [WIDTH-1:0]  gpio_o;
    logic [WIDTH-1:0]  rise_o;
    logic [WIDTH-1:0]  fall_o;

    modport master (
        output pad_din_i, pad_ie_i, filt_en_i, filt_thresh_i,
        input  gpio_o, rise_o, fall_o
    );

    modport slave (
        input  pad_din_i, pad_ie_i, filt_en_i, filt_thresh_i,
        output gpio_o, rise_o, fall_o
    );
endinterface

// File: rtl/pad_gpio_sync.sv
// Gates pad inputs with their enable, synchronises them into clk_i, applies a
// per-pin glitch filter and emits one-cycle rise/fall pulses of the result.
module pad_gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int FILT_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pad_gpio_sync_if.slave   bus
);
    logic [WIDTH-1:0]                   w_masked;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]  r_sync;
    logic [WIDTH-1:0]                   w_sync;
    logic [WIDTH-1:0]                   r_gpio;
    logic [WIDTH-1:0]                   r_rise;
    logic [WIDTH-1:0]                   r_fall;
    logic [WIDTH-1:0][FILT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]                   w_gpio_nxt;
    logic [WIDTH-1:0][FILT_W-1:0]       w_cnt_nxt;

    // Masking happens before the first flop so a disabled pad never toggles the synchroniser.
    assign w_masked = bus.pad_din_i & bus.pad_ie_i;
    assign w_sync   = r_sync[SYNC_STAGES-1];

    // NOTE: every flop, counters included, is cleared by the async reset so a reset mid-count discards it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments keep each stage one cycle behind the previous one.
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_masked};
        end
    end

    // A change is accepted once the counter has reached the threshold; any matching sample restarts it.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_gpio_nxt = r_gpio;
        w_cnt_nxt  = r_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (!bus.filt_en_i[i]) begin
                w_gpio_nxt[i] = w_sync[i];
                w_cnt_nxt[i]  = '0;
            end else if (w_sync[i] == r_gpio[i]) begin
                w_cnt_nxt[i]  = '0;
            end else if (r_cnt[i] >= bus.filt_thresh_i) begin
                w_gpio_nxt[i] = w_sync[i];
                w_cnt_nxt[i]  = '0;
            end else begin
                w_cnt_nxt[i]  = r_cnt[i] + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gpio <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_cnt  <= '0;
        end else begin
            r_gpio <= w_gpio_nxt;
            r_rise <= w_gpio_nxt & ~r_gpio;
            r_fall <= ~w_gpio_nxt & r_gpio;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign bus.gpio_o = r_gpio;
    assign bus.rise_o = r_rise;
    assign bus.fall_o = r_fall;
endmodule
